sata_cont_engine: RTL and testbench
===================================

# sata_cont_engine

Parametrised link-layer CONT engine sitting between the link layer and the PHY/8b10b interface. TX side suppresses repeated continuable primitives: after `REPEAT_MIN` identical copies it inserts CONT, then scrambled junk, using a registered datapath and an explicit FSM. RX side tracks repeated primitives, resolves CONT-held streams, and reports the current primitive as a one-hot vector. This replaces the fixed two-repeat, combinational-output CONT logic with configurable thresholds, statistics, and protocol-violation flags.

## Interface
Parameters:
- `REPEAT_MIN`, 2: identical TX primitives sent before CONT; legal range 2..15.
- `CNT_W`, 16: width of the saturating statistics counters.
- `SCRAM_SEED`, 32'hC2D2768D: junk scrambler seed, reloaded on every CONT entry.

Ports:
- `clk`, in, 1: link clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `phy_ready`, in, 1: PHY link up.
- `tx_cont_en`, in, 1: enable CONT generation; when low, TX is a registered bypass.
- `ll_tx_din`, in, 32: link-layer TX dword.
- `ll_tx_isk`, in, 1: `ll_tx_din` is a primitive (K28.x in byte 0).
- `ll_tx_last`, in, 1: this primitive must go out verbatim; CONT is suppressed.
- `tx_dout`, out, 32: dword to the PHY.
- `tx_isk`, out, 1: `tx_dout` is a primitive.
- `rx_din`, in, 32: received dword.
- `rx_isk`, in, 4: per-byte K flags; bit 0 qualifies a primitive.
- `rx_prim`, out, `PRIM_N`: one-hot current primitive, CONT-resolved.
- `rx_align`, out, 1: ALIGN received.
- `rx_xrdy_xrdy`, out, 1: X_RDY both directions in the same cycle.
- `rx_cont_err`, out, 1: one-cycle pulse; CONT with no held primitive, or unknown K word in junk.
- `tx_cont_cnt`, out, `CNT_W`: CONTs sent, saturating.
- `rx_cont_cnt`, out, `CNT_W`: CONT streams entered, saturating.

## Operation
TX FSM states:
- `PASS`: input forwarded. Repeat counter `rep` counts consecutive identical continuable primitives.
- `SEND_CONT`: entered when `rep == REPEAT_MIN` and the input still equals the previous primitive. Emits PRIM_CONT with isk=1 for exactly one cycle, then goes to `JUNK`. Increments `tx_cont_cnt`.
- `JUNK`: emits scrambler output with isk=0 while the input repeats.

TX exit and clear rules:
- Exit to `PASS`, forwarding the input in the same output slot with `rep`=1, on any of: different primitive, `ll_tx_isk`=0, `ll_tx_last`, or `tx_cont_en` low.
- ALIGN in on TX always goes out unmodified, sends the FSM to `PASS`, and clears `rep`. The held primitive is then re-sent `REPEAT_MIN` times before a new CONT.
- Non-continuable primitives (SOF, EOF, CONT, ALIGN) never advance `rep`.
- `phy_ready`=0: output forwards input, FSM goes to `PASS`, `rep` clears.

RX FSM states:
- `IDLE`: waits for a continuable primitive.
- `TRACK`: one copy seen, id latched.
- `HELD`: a second identical copy was seen.
- `CONT`: CONT seen while in `HELD`. Increments `rx_cont_cnt`.

RX rules:
- In `HELD` and `CONT`, `rx_prim` asserts the latched id on every CONT, ALIGN or data word.
- A different primitive replaces the id and moves to `TRACK`.
- SOF/EOF assert their own bit and return the FSM to `IDLE`.
- A data word (rx_isk[0]=0) outside `CONT` returns the FSM to `IDLE`.
- CONT in `IDLE` or `TRACK` pulses `rx_cont_err`; the state is unchanged.
- ALIGN sets `rx_align`, never changes state, and is never latched.

Arithmetic and encoding:
- `rep` is a 4-bit counter, saturating at `REPEAT_MIN`.
- Statistics counters saturate at all-ones.

## Timing
- TX latency is 1 cycle: `tx_dout`/`tx_isk` are registered.
- RX latency is 1 cycle: `rx_prim`, `rx_align`, `rx_xrdy_xrdy` and `rx_cont_err` are registered.
- Simultaneous events: `ll_tx_last` together with a repeated primitive yields the primitive, not CONT.
- A change on the same cycle as the `SEND_CONT` decision yields the new primitive.
- Reset values: `tx_dout`=0, `tx_isk`=0, `rx_prim`=0, all flags 0, counters 0, both FSMs in `PASS`/`IDLE`.
- Mid-stream reset: outputs return to reset values asynchronously. The first post-reset primitive is forwarded.

## Structure
- Shared package `sata_prim_pkg` holds:
  - PRIM_* 32-bit constants;
  - `prim_id_e` enum (index into `rx_prim`);
  - `PRIM_N`;
  - `is_continuable()`;
  - `prim_to_id()`;
  - the TX/RX state enums.
- Sub-module: the existing `scrambler`, with prim_scrambler=1, enabled in `JUNK` only and reseeded on `SEND_CONT`.

## Test plan
- SYNC held for 10 cycles, `REPEAT_MIN`=2: output is SYNC, SYNC, CONT, then 7 junk words with isk=0; `tx_cont_cnt`=1.
- X_RDY×6 then R_IP with `ll_tx_last` on the 4th cycle: the 4th word is X_RDY (no CONT), CONT follows on the 6th; R_IP goes out verbatim the next cycle.
- HOLD, HOLD, ALIGN, HOLD×4 on TX: ALIGN passes through; HOLD is re-sent twice, then CONT.
- RX R_OK, R_OK, CONT, 5 junk words, ALIGN, 2 junk, SYNC: `rx_prim`=R_OK for every word through the junk (ALIGN included) with `rx_align` pulsed; then SYNC; `rx_cont_cnt`=1.
- RX CONT after a single WTRM: `rx_cont_err` pulses once; WTRM is not held.
- Assert `rst_n` low during TX `JUNK`: outputs go to 0 immediately; after release the next SYNC is forwarded with isk=1.

Source files
------------

// File: rtl/sata_prim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sata_prim_pkg
//  Description : SATA primitive encodings, primitive ids, FSM state types
//                and helpers shared by the CONT engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package sata_prim_pkg;

   localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
   localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
   localparam logic [31:0] PRIM_CONT  = 32'h9999_AA7C;
   localparam logic [31:0] PRIM_SOF   = 32'h3737_B57C;
   localparam logic [31:0] PRIM_EOF   = 32'hD5D5_B57C;
   localparam logic [31:0] PRIM_X_RDY = 32'h5757_B57C;
   localparam logic [31:0] PRIM_R_RDY = 32'h4A4A_957C;
   localparam logic [31:0] PRIM_R_IP  = 32'h5555_B57C;
   localparam logic [31:0] PRIM_R_OK  = 32'h3535_B57C;
   localparam logic [31:0] PRIM_R_ERR = 32'h5656_B57C;
   localparam logic [31:0] PRIM_HOLD  = 32'hD5D5_AA7C;
   localparam logic [31:0] PRIM_HOLDA = 32'h9595_AA7C;
   localparam logic [31:0] PRIM_WTRM  = 32'h5858_B57C;
   localparam logic [31:0] PRIM_DMAT  = 32'h3636_B57C;

   // Index into the one-hot rx_prim vector; ID_UNKNOWN has no bit.
   typedef enum logic [3:0] {
      ID_ALIGN, ID_SYNC, ID_CONT, ID_SOF, ID_EOF, ID_X_RDY, ID_R_RDY,
      ID_R_IP, ID_R_OK, ID_R_ERR, ID_HOLD, ID_HOLDA, ID_WTRM, ID_DMAT,
      ID_UNKNOWN
   } prim_id_e;

   localparam int PRIM_N = 14;

   typedef enum logic [1:0] {TX_PASS, TX_SEND_CONT, TX_JUNK} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_TRACK, RX_HELD, RX_CONT} rx_state_e;

   function automatic logic is_continuable(input logic [31:0] w);
      logic c;
      case (w)
         PRIM_SYNC, PRIM_X_RDY, PRIM_R_RDY, PRIM_R_IP, PRIM_R_OK,
         PRIM_R_ERR, PRIM_HOLD, PRIM_HOLDA, PRIM_WTRM: c = 1'b1;
         default:                                       c = 1'b0;
      endcase
      return c;
   endfunction

   function automatic prim_id_e prim_to_id(input logic [31:0] w);
      prim_id_e id;
      case (w)
         PRIM_ALIGN: id = ID_ALIGN;
         PRIM_SYNC:  id = ID_SYNC;
         PRIM_CONT:  id = ID_CONT;
         PRIM_SOF:   id = ID_SOF;
         PRIM_EOF:   id = ID_EOF;
         PRIM_X_RDY: id = ID_X_RDY;
         PRIM_R_RDY: id = ID_R_RDY;
         PRIM_R_IP:  id = ID_R_IP;
         PRIM_R_OK:  id = ID_R_OK;
         PRIM_R_ERR: id = ID_R_ERR;
         PRIM_HOLD:  id = ID_HOLD;
         PRIM_HOLDA: id = ID_HOLDA;
         PRIM_WTRM:  id = ID_WTRM;
         PRIM_DMAT:  id = ID_DMAT;
         default:    id = ID_UNKNOWN;
      endcase
      return id;
   endfunction

   function automatic logic [PRIM_N-1:0] prim_onehot(input prim_id_e id);
      logic [PRIM_N-1:0] v;
      v = '0;
      if (id != ID_UNKNOWN) v[id] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sata_cont_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : sata_cont_engine_if
//  Description : Link-layer / PHY signal bundle of the CONT engine.
//                master = link layer + PHY side, slave = the engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sata_cont_engine_if #(parameter int CNT_W = 16);
   import sata_prim_pkg::*;

   logic              phy_ready;
   logic              tx_cont_en;
   logic [31:0]       ll_tx_din;
   logic              ll_tx_isk;
   logic              ll_tx_last;
   logic [31:0]       tx_dout;
   logic              tx_isk;
   logic [31:0]       rx_din;
   logic [3:0]        rx_isk;
   logic [PRIM_N-1:0] rx_prim;
   logic              rx_align;
   logic              rx_xrdy_xrdy;
   logic              rx_cont_err;
   logic [CNT_W-1:0]  tx_cont_cnt;
   logic [CNT_W-1:0]  rx_cont_cnt;

   modport master (
      output phy_ready, tx_cont_en, ll_tx_din, ll_tx_isk, ll_tx_last, rx_din, rx_isk,
      input  tx_dout, tx_isk, rx_prim, rx_align, rx_xrdy_xrdy, rx_cont_err,
             tx_cont_cnt, rx_cont_cnt
   );

   modport slave (
      input  phy_ready, tx_cont_en, ll_tx_din, ll_tx_isk, ll_tx_last, rx_din, rx_isk,
      output tx_dout, tx_isk, rx_prim, rx_align, rx_xrdy_xrdy, rx_cont_err,
             tx_cont_cnt, rx_cont_cnt
   );
endinterface
`default_nettype wire

// File: rtl/sata_cont_engine_scrambler.sv
`default_nettype none
// ============================================================================
//  Module      : scrambler
//  Description : 32-bit-per-clock LFSR junk generator. Output is the current
//                state; reseed loads SEED, en advances 32 bit-steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module scrambler #(
   parameter bit          PRIM_SCRAMBLER = 1'b1,
   parameter logic [31:0] SEED           = 32'hC2D2_768D
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        reseed,
   output logic [31:0] dout
);
   logic [31:0] lfsr_d, lfsr_q, lfsr_next;

   function automatic logic [31:0] advance(input logic [31:0] s, input logic [31:0] taps);
      logic [31:0] r;
      r = s;
      for (int i = 0; i < 32; i++) begin
         r = r[31] ? ({r[30:0], 1'b0} ^ taps) : {r[30:0], 1'b0};
      end
      return r;
   endfunction

   // Primitive-junk and data scramblers use different feedback polynomials.
   generate
      if (PRIM_SCRAMBLER) begin : g_prim
         assign lfsr_next = advance(lfsr_q, 32'h0040_0007);
      end else begin : g_data
         assign lfsr_next = advance(lfsr_q, 32'h04C1_1DB7);
      end
   endgenerate

   // Next-state select: reseed has priority over advance.
   always_comb begin
      lfsr_d = lfsr_q;
      if (reseed)  lfsr_d = SEED;
      else if (en) lfsr_d = lfsr_next;
   end

   // LFSR state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign dout = lfsr_q;
endmodule
`default_nettype wire

// File: rtl/sata_cont_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sata_cont_engine
//  Description : SATA link CONT engine. TX suppresses repeated continuable
//                primitives with CONT + junk; RX resolves CONT-held streams
//                into a one-hot primitive vector. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sata_cont_engine
   import sata_prim_pkg::*;
#(
   parameter int          REPEAT_MIN = 2,
   parameter int          CNT_W      = 16,
   parameter logic [31:0] SCRAM_SEED = 32'hC2D2_768D
) (
   input logic               clk,
   input logic               rst_n,
   sata_cont_engine_if.slave bus
);
   localparam logic [3:0] REP_MAX = 4'(REPEAT_MIN);

   // ---------------- TX ----------------
   tx_state_e        tx_state_d, tx_state_q;
   logic [31:0]      tx_dout_d, tx_dout_q, prev_d, prev_q, scram_dout;
   logic             tx_isk_d, tx_isk_q;
   logic [3:0]       rep_d, rep_q;
   logic [CNT_W-1:0] tx_cnt_d, tx_cnt_q;
   logic             tx_is_align, tx_cont_ok, tx_repeat;

   scrambler #(.PRIM_SCRAMBLER(1'b1), .SEED(SCRAM_SEED)) u_scrambler (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (tx_state_d == TX_JUNK),
      .reseed (tx_state_d == TX_SEND_CONT),
      .dout   (scram_dout)
   );

   // TX decision: forward, insert CONT, or emit junk for the next output slot.
   always_comb begin
      tx_is_align = bus.ll_tx_isk && (bus.ll_tx_din == PRIM_ALIGN);
      tx_cont_ok  = bus.ll_tx_isk && is_continuable(bus.ll_tx_din);
      tx_repeat   = bus.phy_ready && bus.tx_cont_en && tx_cont_ok &&
                    !bus.ll_tx_last && (bus.ll_tx_din == prev_q);
      tx_state_d  = TX_PASS;
      tx_dout_d   = bus.ll_tx_din;
      tx_isk_d    = bus.ll_tx_isk;
      rep_d       = rep_q;
      prev_d      = prev_q;
      tx_cnt_d    = tx_cnt_q;
      if (!bus.phy_ready) begin
         rep_d  = 4'd0;
         prev_d = '0;
      end else if (tx_is_align) begin
         // ALIGN passes through; the held primitive is kept but must be re-sent.
         rep_d = 4'd0;
      end else if (tx_repeat && tx_state_q != TX_PASS) begin
         tx_state_d = TX_JUNK;
         tx_dout_d  = scram_dout;
         tx_isk_d   = 1'b0;
      end else if (tx_repeat && rep_q == REP_MAX) begin
         tx_state_d = TX_SEND_CONT;
         tx_dout_d  = PRIM_CONT;
         tx_isk_d   = 1'b1;
         if (tx_cnt_q != '1) tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end else if (tx_repeat) begin
         rep_d = rep_q + 4'd1;
      end else if (tx_cont_ok) begin
         rep_d  = 4'd1;
         prev_d = bus.ll_tx_din;
      end else if (!bus.ll_tx_isk) begin
         rep_d  = 4'd1;
         prev_d = '0;
      end else begin
         // SOF/EOF/CONT/DMAT/unknown K: never a repeat candidate.
         rep_d  = 4'd0;
         prev_d = '0;
      end
   end

   // TX FSM and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_PASS;
         tx_dout_q  <= '0;
         tx_isk_q   <= 1'b0;
         rep_q      <= 4'd0;
         prev_q     <= '0;
         tx_cnt_q   <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_dout_q  <= tx_dout_d;
         tx_isk_q   <= tx_isk_d;
         rep_q      <= rep_d;
         prev_q     <= prev_d;
         tx_cnt_q   <= tx_cnt_d;
      end
   end

   // ---------------- RX ----------------
   rx_state_e         rx_state_d, rx_state_q;
   prim_id_e          held_d, held_q, rx_id;
   logic [PRIM_N-1:0] rx_prim_d, rx_prim_q, held_vec, own_vec;
   logic              rx_align_d, rx_align_q, rx_xx_d, rx_xx_q, rx_err_d, rx_err_q;
   logic [CNT_W-1:0]  rx_cnt_d, rx_cnt_q;
   logic              rx_k, held_active;

   // RX decision: track repeats, resolve CONT streams, flag violations.
   always_comb begin
      rx_k        = bus.rx_isk[0];
      // A valid primitive carries K in byte 0 only.
      rx_id       = (bus.rx_isk[3:1] == 3'b000) ? prim_to_id(bus.rx_din) : ID_UNKNOWN;
      own_vec     = prim_onehot(rx_id);
      held_vec    = prim_onehot(held_q);
      held_active = (rx_state_q == RX_HELD) || (rx_state_q == RX_CONT);
      rx_state_d  = rx_state_q;
      held_d      = held_q;
      rx_prim_d   = '0;
      rx_align_d  = 1'b0;
      rx_err_d    = 1'b0;
      rx_cnt_d    = rx_cnt_q;
      rx_xx_d     = rx_k && (bus.rx_din == PRIM_X_RDY) &&
                    bus.ll_tx_isk && (bus.ll_tx_din == PRIM_X_RDY);
      if (!rx_k) begin
         if (held_active) rx_prim_d = held_vec;
         if (rx_state_q != RX_CONT) rx_state_d = RX_IDLE;
      end else if (rx_id == ID_ALIGN) begin
         rx_align_d = 1'b1;
         rx_prim_d  = held_active ? held_vec : own_vec;
      end else if (rx_id == ID_CONT) begin
         if (held_active) begin
            rx_prim_d = held_vec;
            if (rx_state_q == RX_HELD) begin
               rx_state_d = RX_CONT;
               if (rx_cnt_q != '1) rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end else begin
            rx_err_d = 1'b1;
         end
      end else if (rx_id == ID_UNKNOWN) begin
         rx_err_d   = (rx_state_q == RX_CONT);
         rx_state_d = RX_IDLE;
      end else if (is_continuable(bus.rx_din)) begin
         rx_prim_d  = own_vec;
         held_d     = rx_id;
         rx_state_d = (rx_state_q != RX_IDLE && rx_id == held_q) ? RX_HELD : RX_TRACK;
      end else begin
         rx_prim_d  = own_vec;
         rx_state_d = RX_IDLE;
      end
   end

   // RX FSM and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= RX_IDLE;
         held_q     <= ID_SYNC;
         rx_prim_q  <= '0;
         rx_align_q <= 1'b0;
         rx_xx_q    <= 1'b0;
         rx_err_q   <= 1'b0;
         rx_cnt_q   <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         held_q     <= held_d;
         rx_prim_q  <= rx_prim_d;
         rx_align_q <= rx_align_d;
         rx_xx_q    <= rx_xx_d;
         rx_err_q   <= rx_err_d;
         rx_cnt_q   <= rx_cnt_d;
      end
   end

   assign bus.tx_dout      = tx_dout_q;
   assign bus.tx_isk       = tx_isk_q;
   assign bus.tx_cont_cnt  = tx_cnt_q;
   assign bus.rx_prim      = rx_prim_q;
   assign bus.rx_align     = rx_align_q;
   assign bus.rx_xrdy_xrdy = rx_xx_q;
   assign bus.rx_cont_err  = rx_err_q;
   assign bus.rx_cont_cnt  = rx_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_sata_cont_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sata_cont_engine
//  Description : Table-driven self-checking bench for sata_cont_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sata_cont_engine;
   import sata_prim_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sata_cont_engine_if #(.CNT_W(16)) bus ();

   sata_cont_engine #(.REPEAT_MIN(2), .CNT_W(16), .SCRAM_SEED(32'hC2D2_768D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic rdy; logic en; logic [31:0] din; logic isk; logic last;
      logic [31:0] edout; logic eisk; bit junk;
   } tx_vec_t;

   typedef struct {
      logic [31:0] din; logic k; bit txx;
      logic [PRIM_N-1:0] eprim; logic ealign; logic eerr; logic exx;
   } rx_vec_t;

   tx_vec_t tx_tab[$];
   tx_vec_t tx_sb[$];
   rx_vec_t rx_tab[$];
   rx_vec_t rx_sb[$];
   tx_vec_t te;
   rx_vec_t re;

   function automatic tx_vec_t tv(input logic rdy, input logic en, input logic [31:0] din,
                                  input logic isk, input logic last, input logic [31:0] edout,
                                  input logic eisk, input bit junk);
      tx_vec_t v;
      v.rdy = rdy; v.en = en; v.din = din; v.isk = isk; v.last = last;
      v.edout = edout; v.eisk = eisk; v.junk = junk;
      return v;
   endfunction

   function automatic tx_vec_t tp(input logic [31:0] din, input logic [31:0] edout);
      return tv(1'b1, 1'b1, din, 1'b1, 1'b0, edout, 1'b1, 1'b0);
   endfunction

   function automatic tx_vec_t tj(input logic [31:0] din);
      return tv(1'b1, 1'b1, din, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
   endfunction

   function automatic rx_vec_t rv(input logic [31:0] din, input logic k, input prim_id_e eid,
                                  input logic ealign, input logic eerr, input bit txx,
                                  input logic exx);
      rx_vec_t v;
      v.din = din; v.k = k; v.txx = txx; v.eprim = prim_onehot(eid);
      v.ealign = ealign; v.eerr = eerr; v.exx = exx;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_true(input string name, input bit cond, input logic [31:0] act);
      checks++;
      if (!cond) begin
         errors++;
         $display("FAIL %s: condition false, value %h", name, act);
      end
   endtask

   task automatic drive_idle();
      bus.phy_ready  = 1'b1;
      bus.tx_cont_en = 1'b1;
      bus.ll_tx_din  = 32'h0;
      bus.ll_tx_isk  = 1'b0;
      bus.ll_tx_last = 1'b0;
      bus.rx_din     = 32'h0;
      bus.rx_isk     = 4'b0000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.tx_dout",  bus.tx_dout, 32'h0);
      chk("reset.tx_isk",   32'(bus.tx_isk), 32'h0);
      chk("reset.rx_prim",  32'(bus.rx_prim), 32'h0);
      chk("reset.flags",    {29'h0, bus.rx_align, bus.rx_xrdy_xrdy, bus.rx_cont_err}, 32'h0);
      chk("reset.tx_cnt",   32'(bus.tx_cont_cnt), 32'h0);
      chk("reset.rx_cnt",   32'(bus.rx_cont_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- TX table ----------------
      tx_tab.push_back(tp(PRIM_SYNC, PRIM_SYNC));
      tx_tab.push_back(tp(PRIM_SYNC, PRIM_SYNC));
      tx_tab.push_back(tp(PRIM_SYNC, PRIM_CONT));
      for (int j = 0; j < 7; j++) tx_tab.push_back(tj(PRIM_SYNC));
      tx_tab.push_back(tp(PRIM_X_RDY, PRIM_X_RDY));
      tx_tab.push_back(tp(PRIM_X_RDY, PRIM_X_RDY));
      tx_tab.push_back(tp(PRIM_X_RDY, PRIM_CONT));
      tx_tab.push_back(tv(1'b1, 1'b1, PRIM_X_RDY, 1'b1, 1'b1, PRIM_X_RDY, 1'b1, 1'b0));
      tx_tab.push_back(tp(PRIM_X_RDY, PRIM_X_RDY));
      tx_tab.push_back(tp(PRIM_X_RDY, PRIM_CONT));
      tx_tab.push_back(tp(PRIM_R_IP, PRIM_R_IP));
      tx_tab.push_back(tp(PRIM_HOLD, PRIM_HOLD));
      tx_tab.push_back(tp(PRIM_HOLD, PRIM_HOLD));
      tx_tab.push_back(tp(PRIM_ALIGN, PRIM_ALIGN));
      tx_tab.push_back(tp(PRIM_HOLD, PRIM_HOLD));
      tx_tab.push_back(tp(PRIM_HOLD, PRIM_HOLD));
      tx_tab.push_back(tp(PRIM_HOLD, PRIM_CONT));
      tx_tab.push_back(tj(PRIM_HOLD));
      for (int j = 0; j < 4; j++)
         tx_tab.push_back(tv(1'b1, 1'b0, PRIM_SYNC, 1'b1, 1'b0, PRIM_SYNC, 1'b1, 1'b0));
      tx_tab.push_back(tv(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0));
      tx_tab.push_back(tp(PRIM_R_RDY, PRIM_R_RDY));
      tx_tab.push_back(tp(PRIM_R_RDY, PRIM_R_RDY));
      tx_tab.push_back(tp(PRIM_R_OK, PRIM_R_OK));
      for (int j = 0; j < 3; j++)
         tx_tab.push_back(tv(1'b0, 1'b1, PRIM_WTRM, 1'b1, 1'b0, PRIM_WTRM, 1'b1, 1'b0));
      tx_tab.push_back(tp(PRIM_WTRM, PRIM_WTRM));
      tx_tab.push_back(tp(PRIM_WTRM, PRIM_WTRM));
      tx_tab.push_back(tp(PRIM_WTRM, PRIM_CONT));

      for (int i = 0; i < tx_tab.size(); i++) begin
         bus.phy_ready  = tx_tab[i].rdy;
         bus.tx_cont_en = tx_tab[i].en;
         bus.ll_tx_din  = tx_tab[i].din;
         bus.ll_tx_isk  = tx_tab[i].isk;
         bus.ll_tx_last = tx_tab[i].last;
         tx_sb.push_back(tx_tab[i]);
         @(posedge clk);
         #1;
         te = tx_sb.pop_front();
         if (te.junk) begin
            chk($sformatf("tx[%0d].junk_isk", i), 32'(bus.tx_isk), 32'h0);
            chk_true($sformatf("tx[%0d].junk_word", i),
                     (bus.tx_dout !== te.din) && (bus.tx_dout !== PRIM_CONT), bus.tx_dout);
         end else begin
            chk($sformatf("tx[%0d].dout", i), bus.tx_dout, te.edout);
            chk($sformatf("tx[%0d].isk", i), 32'(bus.tx_isk), 32'(te.eisk));
         end
      end
      chk("tx_cont_cnt", 32'(bus.tx_cont_cnt), 32'd5);

      // ---------------- RX table ----------------
      drive_idle();
      rx_tab.push_back(rv(PRIM_R_OK, 1'b1, ID_R_OK, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_R_OK, 1'b1, ID_R_OK, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_CONT, 1'b1, ID_R_OK, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int j = 0; j < 5; j++)
         rx_tab.push_back(rv(32'hA5A5_0000 + 32'(j), 1'b0, ID_R_OK, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_ALIGN, 1'b1, ID_R_OK, 1'b1, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(32'h1357_9BDF, 1'b0, ID_R_OK, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(32'h2468_ACE0, 1'b0, ID_R_OK, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_SYNC, 1'b1, ID_SYNC, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_WTRM, 1'b1, ID_WTRM, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_CONT, 1'b1, ID_UNKNOWN, 1'b0, 1'b1, 1'b0, 1'b0));
      rx_tab.push_back(rv(32'h0000_1111, 1'b0, ID_UNKNOWN, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(32'h0000_2222, 1'b0, ID_UNKNOWN, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_X_RDY, 1'b1, ID_X_RDY, 1'b0, 1'b0, 1'b1, 1'b1));
      rx_tab.push_back(rv(PRIM_X_RDY, 1'b1, ID_X_RDY, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_SOF, 1'b1, ID_SOF, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(32'h0000_3333, 1'b0, ID_UNKNOWN, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_HOLD, 1'b1, ID_HOLD, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_HOLD, 1'b1, ID_HOLD, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(32'h0000_4444, 1'b0, ID_HOLD, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(32'h0000_5555, 1'b0, ID_UNKNOWN, 1'b0, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_ALIGN, 1'b1, ID_ALIGN, 1'b1, 1'b0, 1'b0, 1'b0));
      rx_tab.push_back(rv(PRIM_CONT, 1'b1, ID_UNKNOWN, 1'b0, 1'b1, 1'b0, 1'b0));

      for (int i = 0; i < rx_tab.size(); i++) begin
         bus.rx_din    = rx_tab[i].din;
         bus.rx_isk    = {3'b000, rx_tab[i].k};
         bus.ll_tx_din = rx_tab[i].txx ? PRIM_X_RDY : 32'h0;
         bus.ll_tx_isk = rx_tab[i].txx;
         rx_sb.push_back(rx_tab[i]);
         @(posedge clk);
         #1;
         re = rx_sb.pop_front();
         chk($sformatf("rx[%0d].prim", i),  32'(bus.rx_prim), 32'(re.eprim));
         chk($sformatf("rx[%0d].align", i), 32'(bus.rx_align), 32'(re.ealign));
         chk($sformatf("rx[%0d].err", i),   32'(bus.rx_cont_err), 32'(re.eerr));
         chk($sformatf("rx[%0d].xx", i),    32'(bus.rx_xrdy_xrdy), 32'(re.exx));
      end
      chk("rx_cont_cnt", 32'(bus.rx_cont_cnt), 32'd1);

      // ---------------- mid-stream reset during TX junk ----------------
      drive_idle();
      bus.ll_tx_din = PRIM_SYNC;
      bus.ll_tx_isk = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_rst.junk_isk", 32'(bus.tx_isk), 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst.tx_dout", bus.tx_dout, 32'h0);
      chk("async_rst.tx_isk",  32'(bus.tx_isk), 32'h0);
      chk("async_rst.tx_cnt",  32'(bus.tx_cont_cnt), 32'h0);
      chk("async_rst.rx_cnt",  32'(bus.rx_cont_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst.dout", bus.tx_dout, PRIM_SYNC);
      chk("post_rst.isk",  32'(bus.tx_isk), 32'h1);
      @(posedge clk);
      #1;
      chk("post_rst.dout2", bus.tx_dout, PRIM_SYNC);
      @(posedge clk);
      #1;
      chk("post_rst.cont", bus.tx_dout, PRIM_CONT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
